// File: rtl/arb_serial_pkg.sv
// Shared state encoding, default width and parity helper for the serial requester slice.
package arb_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SHIFT,
    RELEASE
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  // Zero-extending the word before the XOR does not change the result.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/arb_serial_requester_if.sv
// Local-writer, arbiter and serial-output signals of one requester.
// The master modport is the requester's view and the slave modport is the environment's view.
interface arb_serial_requester_if
  import arb_serial_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic              req;
  logic              gnt;
  logic              ser_out;
  logic              ser_valid;
  logic              abort;

  modport master (
    input  wr_en, wr_data, gnt,
    output full, empty, req, ser_out, ser_valid, abort
  );

  modport slave (
    output wr_en, wr_data, gnt,
    input  full, empty, req, ser_out, ser_valid, abort
  );

endinterface

// File: rtl/arb_serial_fifo.sv
// Small DEPTH x DATA_W word buffer with a combinational head word.
// full and empty come from a registered occupancy count.
module arb_serial_fifo
  import arb_serial_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              wr_ok, rd_ok;

  // A write into a full buffer is dropped even when a pop happens in the same cycle.
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_ok && !rd_ok)      count_reg <= count_reg + 1'b1;
      else if (rd_ok && !wr_ok) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/arb_serial_requester.sv
// Requester-side arbiter client: buffers words, requests a grant, then shifts each word out LSB-first.
// Defining SERIAL_PARITY_EN appends one even-parity bit to each frame.
module arb_serial_requester
  import arb_serial_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  arb_serial_requester_if.master bus
);

`ifdef SERIAL_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  state_t             state_reg, state_next;
  logic               req_reg, req_next;
  logic               ser_out_reg, ser_out_next;
  logic               ser_valid_reg, ser_valid_next;
  logic               abort_reg, abort_next;
  logic [FRAME_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;

  logic               fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]  fifo_rd_data;
  logic [FRAME_W-1:0] frame_word;

  arb_serial_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef SERIAL_PARITY_EN
  assign frame_word = {even_parity(64'(fifo_rd_data)), fifo_rd_data};
`else
  assign frame_word = fifo_rd_data;
`endif

  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.req       = req_reg;
  assign bus.ser_out   = ser_out_reg;
  assign bus.ser_valid = ser_valid_reg;
  assign bus.abort     = abort_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      req_reg       <= 1'b0;
      ser_out_reg   <= 1'b0;
      ser_valid_reg <= 1'b0;
      abort_reg     <= 1'b0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      req_reg       <= req_next;
      ser_out_reg   <= ser_out_next;
      ser_valid_reg <= ser_valid_next;
      abort_reg     <= abort_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    req_next       = req_reg;
    ser_out_next   = ser_out_reg;
    ser_valid_next = ser_valid_reg;
    abort_next     = 1'b0;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    fifo_pop       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          req_next   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.gnt) begin
          fifo_pop       = 1'b1;
          shift_next     = frame_word;
          ser_out_next   = frame_word[0];
          ser_valid_next = 1'b1;
          bit_cnt_next   = '0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        // A lost grant ends the frame; the popped word is discarded, not re-queued.
        if (!bus.gnt) begin
          abort_next     = 1'b1;
          ser_valid_next = 1'b0;
          ser_out_next   = 1'b0;
          req_next       = 1'b0;
          state_next     = RELEASE;
        end else if (bit_cnt_reg == LAST_CNT) begin
          ser_valid_next = 1'b0;
          ser_out_next   = 1'b0;
          req_next       = 1'b0;
          state_next     = RELEASE;
        end else begin
          shift_next     = shift_reg >> 1;
          ser_out_next   = shift_reg[1];
          bit_cnt_next   = bit_cnt_reg + 1'b1;
        end
      end
      RELEASE: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arb_serial_requester.sv
// Directed bench for arb_serial_requester: reset, single word, grant delay, overflow, abort, mid-frame reset.
// Parity bits are checked when the bench is built with SERIAL_PARITY_EN.
module tb_arb_serial_requester;

`ifdef SERIAL_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  arb_serial_requester_if #(.DATA_W(8)) bus ();

  arb_serial_requester #(
    .DEPTH  (4),
    .DATA_W (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clock);
    bus.wr_en   = 1'b0;
    $display("write %02h full=%0b empty=%0b", d, bus.full, bus.empty);
  endtask

  // exp_bits holds the hand-computed frame, bit 8 being the parity bit.
  task automatic expect_frame(input string tag, input logic [8:0] exp_bits);
    int waited = 0;
    while (bus.ser_valid !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check({tag, "_start"}, 32'(bus.ser_valid), 32'd1);
    for (int i = 0; i < FRAME_BITS; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(bus.ser_valid), 32'd1);
      check($sformatf("%s_bit%0d", tag, i), 32'(bus.ser_out), 32'(exp_bits[i]));
      @(negedge clock);
    end
    check({tag, "_end_valid"}, 32'(bus.ser_valid), 32'd0);
    check({tag, "_end_req"}, 32'(bus.req), 32'd0);
    $display("frame %s expected %03h done", tag, exp_bits);
  endtask

  initial begin
    int seen;
    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.gnt     = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_valid", 32'(bus.ser_valid), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_abort", 32'(bus.abort), 32'd0);
    check("rst_ser_out", 32'(bus.ser_out), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single word with the grant tied high.
    bus.gnt = 1'b1;
    write_word(8'hA5);
    check("a5_req_at_n", 32'(bus.req), 32'd0);
    check("a5_not_empty", 32'(bus.empty), 32'd0);
    @(negedge clock);
    check("a5_req_at_n1", 32'(bus.req), 32'd1);
    check("a5_valid_at_n1", 32'(bus.ser_valid), 32'd0);
    expect_frame("a5", 9'h0A5);
    @(negedge clock);
    check("a5_gap_req", 32'(bus.req), 32'd0);
    check("a5_empty", 32'(bus.empty), 32'd1);
    repeat (3) @(negedge clock);

    // Grant withheld for 20 cycles.
    bus.gnt = 1'b0;
    write_word(8'h3C);
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("3c_wait_req%0d", i), 32'(bus.req), 32'd1);
      check($sformatf("3c_wait_valid%0d", i), 32'(bus.ser_valid), 32'd0);
      @(negedge clock);
    end
    bus.gnt = 1'b1;
    expect_frame("3c", 9'h03C);
    repeat (3) @(negedge clock);

    // Overflow: the fifth word must be dropped.
    bus.gnt = 1'b0;
    write_word(8'h01);
    write_word(8'h02);
    write_word(8'h03);
    check("ovf_not_full3", 32'(bus.full), 32'd0);
    write_word(8'h04);
    check("ovf_full4", 32'(bus.full), 32'd1);
    write_word(8'h05);
    check("ovf_full5", 32'(bus.full), 32'd1);
    check("ovf_req", 32'(bus.req), 32'd1);
    bus.gnt = 1'b1;
    expect_frame("ovf01", 9'h101);
    check("ovf_not_full_after_pop", 32'(bus.full), 32'd0);
    expect_frame("ovf02", 9'h102);
    expect_frame("ovf03", 9'h003);
    expect_frame("ovf04", 9'h104);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (bus.ser_valid === 1'b1) seen++;
    end
    check("ovf_no_fifth", 32'(seen), 32'd0);
    check("ovf_empty", 32'(bus.empty), 32'd1);

    // Abort: grant dropped after the third bit of FF.
    bus.gnt = 1'b0;
    write_word(8'hFF);
    write_word(8'h5A);
    bus.gnt = 1'b1;
    seen = 0;
    while (bus.ser_valid !== 1'b1 && seen < 40) begin
      @(negedge clock);
      seen++;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ff_bit%0d", i), 32'(bus.ser_out), 32'd1);
      check($sformatf("ff_valid%0d", i), 32'(bus.ser_valid), 32'd1);
      if (i < 2) @(negedge clock);
    end
    bus.gnt = 1'b0;
    @(negedge clock);
    check("ff_abort", 32'(bus.abort), 32'd1);
    check("ff_abort_valid", 32'(bus.ser_valid), 32'd0);
    check("ff_abort_req", 32'(bus.req), 32'd0);
    bus.gnt = 1'b1;
    @(negedge clock);
    check("ff_abort_once", 32'(bus.abort), 32'd0);
    check("ff_release_req", 32'(bus.req), 32'd0);
    expect_frame("5a", 9'h05A);
    check("5a_empty", 32'(bus.empty), 32'd1);
    repeat (3) @(negedge clock);

    // Parity pair (only the data bits matter without SERIAL_PARITY_EN).
    write_word(8'h07);
    write_word(8'h03);
    expect_frame("07", 9'h107);
    expect_frame("03", 9'h003);
    repeat (3) @(negedge clock);

    // Mid-frame reset discards the frame and the queue.
    bus.gnt = 1'b0;
    write_word(8'h11);
    write_word(8'h22);
    bus.gnt = 1'b1;
    seen = 0;
    while (bus.ser_valid !== 1'b1 && seen < 40) begin
      @(negedge clock);
      seen++;
    end
    check("mid_in_frame", 32'(bus.ser_valid), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("mid_valid", 32'(bus.ser_valid), 32'd0);
    check("mid_req", 32'(bus.req), 32'd0);
    check("mid_empty", 32'(bus.empty), 32'd1);
    check("mid_full", 32'(bus.full), 32'd0);
    repeat (4) @(negedge clock);
    check("mid_stays_idle", 32'(bus.req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
